td4x_core: RTL and testbench
============================

// Module: td4x_core
// PURPOSE
//  Parametrised successor of the 4-bit TD4 CPU core: same 12-instruction accumulator ISA.
//  Data/address width is DW; instruction fetch has a valid handshake; HLT opcode added.
//  Adds a registered output-write strobe. Sits between an external program ROM (adr/instr) and the I/O pins.
// PARAMETERS
//  DW        4       data, immediate and program-address width (DW >= 2)
//  RST_PC    0       PC value loaded on reset (DW bits)
// PORTS
//  clk          in   1      clock, rising edge
//  reset        in   1      asynchronous, active-high
//  adr          out  DW     program address (= PC)
//  instr        in   DW+4   {opcode[3:0], imm[DW-1:0]} for adr, sampled when instr_valid=1
//  instr_valid  in   1      instr is valid this cycle; 0 = stall
//  in_port      in   DW     input port
//  out_port     out  DW     output register
//  out_strobe   out  1      1-cycle pulse the cycle after out_port is written
//  carry        out  1      carry flag C
//  halted       out  1      core is in HALT state
// BEHAVIOUR
//  Reset (async): PC=RST_PC, A=B=out_port=0, C=0, out_strobe=0, state=RUN, halted=0.
//  FSM: RUN -> HALT on executed HLT; HALT is absorbing, left only via reset.
//  RUN: one instruction per cycle when instr_valid=1.
//    instr_valid=0: all state (PC, A, B, OUT, C) holds; out_strobe=0.
//  HALT: all state holds; instr/instr_valid ignored; adr holds the PC of the HLT+1.
//  Opcodes (S = source, result R = S + imm mod 2^DW, cout = carry-out):
//    0000 ADD A,Im  A<=A+imm      0001 MOV A,B  A<=B+imm
//    0010 IN A      A<=in+imm     0011 MOV A,Im A<=imm
//    0100 MOV B,A   B<=A+imm      0101 ADD B,Im B<=B+imm
//    0110 IN B      B<=in+imm     0111 MOV B,Im B<=imm
//    1001 OUT B     OUT<=B+imm    1011 OUT Im   OUT<=imm
//    1110 JNC Im    PC<=imm if C==0, else PC+1
//    1111 JMP Im    PC<=imm
//    1010 HLT       PC<=PC+1, enter HALT
//    1000,1100,1101 NOP  PC<=PC+1
//  Immediate: the standard ISA uses imm=0 for MOV/IN/OUT B. Non-zero imm adds to the source.
//  Non-jump executed instr: PC<=PC+1 mod 2^DW (wraps to 0, not RST_PC).
//  C update: every executed instruction loads C<=cout of S+imm.
//    S=0 for MOV Im, OUT Im, JNC, JMP, HLT and NOP, so C<=0 for these.
//    Stalled and HALT cycles hold C.
//  JNC tests C as left by the previous executed instruction (pre-update value).
//  out_strobe=1 in the cycle after an executed OUT B or OUT Im, else 0.
//    Back-to-back OUTs give a continuous high strobe.
//  Register write takes effect at the clock edge. Single-cycle latency, no forwarding needed.
//  Reset asserted mid-stall or in HALT: immediate return to the reset values above.
// STRUCTURE
//  td4x_pkg: opcode localparams (OP_ADD_A ... OP_JMP, OP_HLT); state enum {ST_RUN, ST_HALT}.
//  Sub-module td4x_alu (DW): 4:1 source mux (A, B, in_port, 0) + DW-bit adder -> {cout, sum}.
//  Core: decode, registers A/B/OUT/C/PC, FSM and strobe. Reuse the common register and counter cells.
// TESTING
//  1 Reset, DW=4, program MOV A,3; ADD A,15 -> A=2, C=1; next instr C<=0 (MOV B,A gives B=2).
//  2 ADD A,1 x16 from A=0, then JNC 0 -> JNC at wrap falls through; PC wraps 15->0 on sequential run.
//  3 instr_valid low 5 cycles mid-program -> PC/A/B/C/out_port unchanged; adr stable.
//  4 OUT Im 9; OUT B (B=5) -> out_port 9 then 5; out_strobe high for 2 cycles, one cycle late.
//  5 HLT at adr 6 -> halted=1, adr=7 held; toggling instr/instr_valid has no effect; reset -> PC=RST_PC.
//  6 DW=8, IN A with in_port=0xF0, ADD A,0x20 -> A=0x10, C=1; JNC 0x80 not taken, PC+1.

Source files
------------

// File: rtl/td4x_pkg.sv
// Shared definitions for the td4x accumulator core: opcode encodings,
// ALU source selects and the run/halt state type.
package td4x_pkg;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_AI = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_BI = 4'b0111;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_HLT    = 4'b1010;
  localparam logic [3:0] OP_OUT_I  = 4'b1011;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  localparam logic [1:0] SRC_A    = 2'd0;
  localparam logic [1:0] SRC_B    = 2'd1;
  localparam logic [1:0] SRC_IN   = 2'd2;
  localparam logic [1:0] SRC_ZERO = 2'd3;

  typedef enum logic {ST_RUN, ST_HALT} state_t;

endpackage

// File: rtl/td4x_alu.sv
// Source mux plus DW-bit adder; purely combinational, result = src + imm with carry-out.
module td4x_alu
  import td4x_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic [1:0]    src_sel,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] in_port,
  input  logic [DW-1:0] imm,
  output logic [DW-1:0] sum,
  output logic          cout
);

  logic [DW-1:0] src;

  always_comb begin
    src = '0;
    case (src_sel)
      SRC_A:   src = a;
      SRC_B:   src = b;
      SRC_IN:  src = in_port;
      default: src = '0;
    endcase
  end

  assign {cout, sum} = {1'b0, src} + {1'b0, imm};

endmodule

// File: rtl/td4x_core.sv
// Accumulator CPU core: one instruction per cycle while instr_valid, stalls hold all state.
// Register writes land at the clock edge; out_strobe is registered alongside out_port.
module td4x_core
  import td4x_pkg::*;
#(
  parameter int              DW     = 4,
  parameter logic [DW-1:0]   RST_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  output logic [DW-1:0] adr,
  input  logic [DW+3:0] instr,
  input  logic          instr_valid,
  input  logic [DW-1:0] in_port,
  output logic [DW-1:0] out_port,
  output logic          out_strobe,
  output logic          carry,
  output logic          halted
);

  state_t        state, state_next;
  logic [DW-1:0] pc, reg_a, reg_b;
  logic [3:0]    opcode;
  logic [DW-1:0] imm, sum, pc_next;
  logic [1:0]    src_sel;
  logic          cout, exec;
  logic          wr_a, wr_b, wr_out, jump, hlt;

  assign opcode = instr[DW+3:DW];
  assign imm    = instr[DW-1:0];
  assign exec   = (state == ST_RUN) && instr_valid;
  assign adr    = pc;
  assign halted = (state == ST_HALT);

  td4x_alu #(.DW(DW)) u_alu (
    .src_sel (src_sel),
    .a       (reg_a),
    .b       (reg_b),
    .in_port (in_port),
    .imm     (imm),
    .sum     (sum),
    .cout    (cout)
  );

  // Decode; jump-type, HLT and NOP opcodes add imm to zero so C clears.
  always_comb begin
    src_sel = SRC_ZERO;
    wr_a    = 1'b0;
    wr_b    = 1'b0;
    wr_out  = 1'b0;
    jump    = 1'b0;
    hlt     = 1'b0;
    case (opcode)
      OP_ADD_A:  begin src_sel = SRC_A;  wr_a = 1'b1; end
      OP_MOV_AB: begin src_sel = SRC_B;  wr_a = 1'b1; end
      OP_IN_A:   begin src_sel = SRC_IN; wr_a = 1'b1; end
      OP_MOV_AI: wr_a = 1'b1;
      OP_MOV_BA: begin src_sel = SRC_A;  wr_b = 1'b1; end
      OP_ADD_B:  begin src_sel = SRC_B;  wr_b = 1'b1; end
      OP_IN_B:   begin src_sel = SRC_IN; wr_b = 1'b1; end
      OP_MOV_BI: wr_b = 1'b1;
      OP_OUT_B:  begin src_sel = SRC_B;  wr_out = 1'b1; end
      OP_OUT_I:  wr_out = 1'b1;
      OP_JNC:    jump = ~carry;
      OP_JMP:    jump = 1'b1;
      OP_HLT:    hlt = 1'b1;
      default:   ;
    endcase
  end

  assign pc_next = jump ? imm : pc + {{(DW-1){1'b0}}, 1'b1};

  always_comb begin
    state_next = state;
    if (exec && hlt) state_next = ST_HALT;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_RUN;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc         <= RST_PC;
      reg_a      <= '0;
      reg_b      <= '0;
      out_port   <= '0;
      carry      <= 1'b0;
      out_strobe <= 1'b0;
    end else begin
      out_strobe <= exec && wr_out;
      if (exec) begin
        pc    <= pc_next;
        carry <= cout;
        if (wr_a)   reg_a    <= sum;
        if (wr_b)   reg_b    <= sum;
        if (wr_out) out_port <= sum;
      end
    end
  end

endmodule

// File: tb/tb_td4x_core.sv
// Directed bench for td4x_core: a DW=4 core with RST_PC=0 and a DW=8 core with RST_PC=0x10.
module tb_td4x_core;
  import td4x_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic [3:0]  adr4, in4, out4;
  logic [7:0]  instr4 = '0;
  logic        valid4 = 1'b0;
  logic        strobe4, carry4, halted4;

  logic [7:0]  adr8, in8, out8;
  logic [11:0] instr8 = '0;
  logic        valid8 = 1'b0;
  logic        strobe8, carry8, halted8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  td4x_core #(.DW(4), .RST_PC(4'h0)) u4 (
    .clk(clk), .reset(reset), .adr(adr4), .instr(instr4), .instr_valid(valid4),
    .in_port(in4), .out_port(out4), .out_strobe(strobe4), .carry(carry4), .halted(halted4)
  );

  td4x_core #(.DW(8), .RST_PC(8'h10)) u8 (
    .clk(clk), .reset(reset), .adr(adr8), .instr(instr8), .instr_valid(valid8),
    .in_port(in8), .out_port(out8), .out_strobe(strobe8), .carry(carry8), .halted(halted8)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are read 1 unit after the next edge.
  task automatic step4(input logic [3:0] op, input logic [3:0] imm);
    instr4 = {op, imm};
    valid4 = 1'b1;
    @(posedge clk); #1;
    valid4 = 1'b0;
  endtask

  task automatic step8(input logic [3:0] op, input logic [7:0] imm);
    instr8 = {op, imm};
    valid8 = 1'b1;
    @(posedge clk); #1;
    valid8 = 1'b0;
  endtask

  initial begin
    in4 = 4'h0;
    in8 = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_adr", 16'(adr4), 16'h0);
    check("rst_out", 16'(out4), 16'h0);
    check("rst_strobe", 16'(strobe4), 16'h0);
    check("rst_carry", 16'(carry4), 16'h0);
    check("rst_halted", 16'(halted4), 16'h0);
    check("rst_adr8", 16'(adr8), 16'h10);
    reset = 1'b0;

    // MOV A,3; ADD A,15 -> A=2 C=1; MOV B,A clears C; OUT B shows A
    step4(OP_MOV_AI, 4'd3);
    step4(OP_ADD_A, 4'd15);
    check("add_carry", 16'(carry4), 16'h1);
    check("add_adr", 16'(adr4), 16'h2);
    step4(OP_MOV_BA, 4'd0);
    check("movba_carry", 16'(carry4), 16'h0);
    step4(OP_OUT_B, 4'd0);
    check("outb_a", 16'(out4), 16'h2);
    check("outb_strobe", 16'(strobe4), 16'h1);

    // OUT Im 9 then OUT B with B=5: strobe continuous for two cycles
    step4(OP_MOV_BI, 4'd5);
    check("movbi_strobe", 16'(strobe4), 16'h0);
    step4(OP_OUT_I, 4'd9);
    check("outi_port", 16'(out4), 16'h9);
    check("outi_strobe", 16'(strobe4), 16'h1);
    step4(OP_OUT_B, 4'd0);
    check("outb5_port", 16'(out4), 16'h5);
    check("outb5_strobe", 16'(strobe4), 16'h1);
    step4(4'b1000, 4'd7);
    check("nop_strobe", 16'(strobe4), 16'h0);
    check("nop_adr", 16'(adr4), 16'h8);

    // Set C=1 (A=2+15=1), then stall 5 cycles with an OUT/JMP on the bus
    step4(OP_ADD_A, 4'd15);
    check("pre_stall_carry", 16'(carry4), 16'h1);
    instr4 = {OP_OUT_I, 4'd3};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_adr", 16'(adr4), 16'h9);
      check("stall_strobe", 16'(strobe4), 16'h0);
      instr4 = {OP_JMP, 4'(i)};
    end
    check("stall_carry", 16'(carry4), 16'h1);
    check("stall_out", 16'(out4), 16'h5);
    step4(OP_MOV_BA, 4'd0);
    step4(OP_OUT_B, 4'd0);
    check("stall_a_kept", 16'(out4), 16'h1);
    check("post_stall_adr", 16'(adr4), 16'hB);

    // A=0, 16x ADD A,1: PC wraps 15->0, carry only on the 16th
    step4(OP_MOV_AI, 4'd0);
    for (int i = 1; i <= 16; i++) begin
      step4(OP_ADD_A, 4'd1);
      if (i == 4)  check("pc_wrap", 16'(adr4), 16'h0);
      if (i == 15) check("add15_carry", 16'(carry4), 16'h0);
    end
    check("add16_carry", 16'(carry4), 16'h1);
    check("add16_adr", 16'(adr4), 16'hC);
    step4(OP_JNC, 4'd0);
    check("jnc_fallthru", 16'(adr4), 16'hD);
    check("jnc_carry", 16'(carry4), 16'h0);
    step4(OP_JNC, 4'd5);
    check("jnc_taken", 16'(adr4), 16'h5);
    step4(OP_JMP, 4'd6);
    check("jmp", 16'(adr4), 16'h6);

    // HLT at 6: adr sticks at 7, inputs ignored, reset recovers
    step4(OP_HLT, 4'd0);
    check("hlt_halted", 16'(halted4), 16'h1);
    check("hlt_adr", 16'(adr4), 16'h7);
    instr4 = {OP_OUT_I, 4'd3};
    valid4 = 1'b1;
    @(posedge clk); #1;
    instr4 = {OP_JMP, 4'd2};
    valid4 = 1'b0;
    @(posedge clk); #1;
    instr4 = {OP_ADD_A, 4'd15};
    valid4 = 1'b1;
    @(posedge clk); #1;
    check("halt_adr_held", 16'(adr4), 16'h7);
    check("halt_out_held", 16'(out4), 16'h1);
    check("halt_strobe", 16'(strobe4), 16'h0);
    check("halt_still", 16'(halted4), 16'h1);
    valid4 = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("halt_rst_adr", 16'(adr4), 16'h0);
    check("halt_rst_halted", 16'(halted4), 16'h0);
    check("halt_rst_out", 16'(out4), 16'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // DW=8: IN A (0xF0) + 0x20 -> 0x10 C=1; JNC 0x80 not taken
    check("w8_rst_adr", 16'(adr8), 16'h10);
    in8 = 8'hF0;
    step8(OP_IN_A, 8'h00);
    in8 = 8'h00;
    step8(OP_ADD_A, 8'h20);
    check("w8_carry", 16'(carry8), 16'h1);
    step8(OP_JNC, 8'h80);
    check("w8_jnc_adr", 16'(adr8), 16'h13);
    check("w8_jnc_carry", 16'(carry8), 16'h0);
    step8(OP_MOV_BA, 8'h00);
    step8(OP_OUT_B, 8'h00);
    check("w8_a_val", 16'(out8), 16'h10);
    check("w8_strobe", 16'(strobe8), 16'h1);
    step8(OP_JMP, 8'hFF);
    step8(4'b1100, 8'h00);
    check("w8_wrap_zero", 16'(adr8), 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
